// File: rtl/fetch_unit_pkg.sv
// Shared CPU fetch definitions: FSM state encodings and next-PC select codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_unit_pkg;

  // Fetch FSM: IDLE waits for a free IF/ID slot, BUSY owns a live request,
  // DROP waits out a request whose data must be thrown away.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DROP = 2'b10
  } fetch_state_e;

  // Next-PC select codes; code 2'b11 also selects the jump target (bit 1 dominates).
  typedef enum logic [1:0] {
    PC_PLUS4  = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JUMP   = 2'b10
  } pcsrc_e;

  localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory request/response bus between fetch and imem.
// Latency: request held until imem_ready; data valid in the imem_ready cycle.
// Backpressure: memory stalls the fetch by holding imem_ready low.
interface fetch_unit_if #(
  parameter int WIDTH = 32
);
  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_ready;
  logic [WIDTH-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit_mux3.sv
// Width-parameterised 3-input mux for next-PC selection.
// Latency: combinational.
// Backpressure: none.
module fetch_unit_mux3
  import fetch_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] y
);

  // Select bit 1 dominates so both 10 and 11 pick d2.
  always_comb begin
    y = d0;
    if (sel[1]) begin
      y = d2;
    end else if (sel == PC_BRANCH) begin
      y = d1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, single outstanding imem request, IF/ID register.
// Latency: IF/ID valid (memory wait cycles + 1) after a request starts; 1 instr/cycle at zero wait.
// Backpressure: stall holds IF/ID; a word returning into an occupied stalled slot is refetched later.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic [1:0]        pcsrc,
  input  logic [WIDTH-1:0]  branch_target,
  input  logic [WIDTH-1:0]  jump_target,
  fetch_unit_if.master      imem,
  output logic              if_valid,
  output logic [WIDTH-1:0]  if_pc,
  output logic [WIDTH-1:0]  if_pc_plus4,
  output logic [WIDTH-1:0]  if_instr
);

  fetch_state_e     state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] inflight_q, inflight_d;
  logic             if_valid_q, if_valid_d;
  logic [WIDTH-1:0] if_pc_q, if_pc_d;
  logic [WIDTH-1:0] if_pc_plus4_q, if_pc_plus4_d;
  logic [WIDTH-1:0] if_instr_q, if_instr_d;

  logic             redirect;
  logic             slot_free;
  logic             capture;
  logic             load_addr;
  logic [WIDTH-1:0] addr_plus4;
  logic [WIDTH-1:0] next_pc;

  assign redirect   = (pcsrc != PC_PLUS4);
  assign slot_free  = !if_valid_q || !stall;
  assign addr_plus4 = inflight_q + WIDTH'(INSTR_BYTES);

  // The in-flight address equals PC whenever no redirect has intervened,
  // so the sequential path through the mux is the in-flight address + 4.
  fetch_unit_mux3 #(.WIDTH(WIDTH)) u_next_pc_mux (
    .d0  (addr_plus4),
    .d1  (branch_target),
    .d2  (jump_target),
    .sel (pcsrc),
    .y   (next_pc)
  );

  // Next-state, PC and IF/ID update; redirect overrides capture and consumption.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_d    = inflight_q;
    if_valid_d    = if_valid_q;
    if_pc_d       = if_pc_q;
    if_pc_plus4_d = if_pc_plus4_q;
    if_instr_d    = if_instr_q;
    capture       = 1'b0;
    load_addr     = 1'b0;

    if (if_valid_q && !stall) begin
      if_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (slot_free) begin
          state_d   = ST_BUSY;
          load_addr = 1'b1;
        end
      end
      ST_BUSY: begin
        if (redirect) begin
          if (imem.imem_ready) begin
            load_addr = 1'b1;
          end else begin
            state_d = ST_DROP;
          end
        end else if (imem.imem_ready) begin
          if (slot_free) begin
            capture   = 1'b1;
            load_addr = !stall;
            state_d   = stall ? ST_IDLE : ST_BUSY;
          end else begin
            // Slot still held by a stalled instruction: drop the word, PC
            // still points at it, so it is fetched again once decode frees up.
            state_d = ST_IDLE;
          end
        end
      end
      ST_DROP: begin
        if (imem.imem_ready) begin
          state_d   = ST_BUSY;
          load_addr = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (capture) begin
      if_valid_d    = 1'b1;
      if_pc_d       = inflight_q;
      if_pc_plus4_d = addr_plus4;
      if_instr_d    = imem.imem_rdata;
    end

    if (redirect || capture) begin
      pc_d = next_pc;
    end

    if (redirect) begin
      if_valid_d = 1'b0;
    end

    if (load_addr) begin
      inflight_d = pc_d;
    end
  end

  // State, PC, in-flight address and IF/ID registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      inflight_q    <= '0;
      if_valid_q    <= 1'b0;
      if_pc_q       <= '0;
      if_pc_plus4_q <= '0;
      if_instr_q    <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      if_valid_q    <= if_valid_d;
      if_pc_q       <= if_pc_d;
      if_pc_plus4_q <= if_pc_plus4_d;
      if_instr_q    <= if_instr_d;
    end
  end

  assign imem.imem_req  = (state_q != ST_IDLE);
  assign imem.imem_addr = inflight_q;

  assign if_valid    = if_valid_q;
  assign if_pc       = if_pc_q;
  assign if_pc_plus4 = if_pc_plus4_q;
  assign if_instr    = if_instr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit: per-cycle vector table plus reset sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic [1:0]  pcsrc;
  logic [31:0] btgt;
  logic [31:0] jtgt;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
  logic [31:0] if_instr;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_unit_if #(.WIDTH(32)) bus();

  fetch_unit #(.WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .pcsrc         (pcsrc),
    .branch_target (btgt),
    .jump_target   (jtgt),
    .imem          (bus),
    .if_valid      (if_valid),
    .if_pc         (if_pc),
    .if_pc_plus4   (if_pc4),
    .if_instr      (if_instr)
  );

  always #5 clk = ~clk;

  // Memory model: word = {16'hDEAD, addr[15:0]} in the ready cycle.
  assign bus.imem_rdata = bus.imem_ready ? {16'hDEAD, bus.imem_addr[15:0]} : 32'hBAD0_BAD0;

  typedef struct {
    logic        stall;
    logic [1:0]  pcsrc;
    logic [31:0] bt;
    logic [31:0] jt;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_pc4;
    logic [31:0] e_instr;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic row(input logic stl, input logic [1:0] ps, input logic [31:0] bt, input logic [31:0] jt,
                     input logic rdy, input logic er, input logic [31:0] ea, input logic ev,
                     input logic [31:0] ep, input logic [31:0] ep4, input logic [31:0] ei);
    vecs.push_back('{stl, ps, bt, jt, rdy, er, ea, ev, ep, ep4, ei});
  endtask

  task automatic check_outputs(input string tag, input logic er, input logic [31:0] ea, input logic ev,
                               input logic [31:0] ep, input logic [31:0] ep4, input logic [31:0] ei);
    check({tag, "_req"},   32'(bus.imem_req), 32'(er));
    check({tag, "_addr"},  bus.imem_addr,     ea);
    check({tag, "_valid"}, 32'(if_valid),     32'(ev));
    check({tag, "_pc"},    if_pc,             ep);
    check({tag, "_pc4"},   if_pc4,            ep4);
    check({tag, "_instr"}, if_instr,          ei);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    // Each row: inputs applied this cycle; expected outputs seen at the cycle start.
    //   stall pcsrc bt            jt            rdy | req addr          valid pc            pc4           instr
    row(0, 2'b00, 32'h0,   32'h0,         1, 0, 32'h0,         0, 32'h0,         32'h0,   32'h0);
    row(0, 2'b00, 32'h0,   32'h0,         1, 1, 32'h0,         0, 32'h0,         32'h0,   32'h0);
    row(0, 2'b00, 32'h0,   32'h0,         1, 1, 32'h4,         1, 32'h0,         32'h4,   32'hDEAD0000);
    row(0, 2'b00, 32'h0,   32'h0,         1, 1, 32'h8,         1, 32'h4,         32'h8,   32'hDEAD0004);
    row(1, 2'b00, 32'h0,   32'h0,         1, 1, 32'hC,         1, 32'h8,         32'hC,   32'hDEAD0008);
    row(1, 2'b00, 32'h0,   32'h0,         0, 0, 32'hC,         1, 32'h8,         32'hC,   32'hDEAD0008);
    row(0, 2'b00, 32'h0,   32'h0,         0, 0, 32'hC,         1, 32'h8,         32'hC,   32'hDEAD0008);
    row(0, 2'b00, 32'h0,   32'h0,         1, 1, 32'hC,         0, 32'h8,         32'hC,   32'hDEAD0008);
    row(0, 2'b01, 32'h100, 32'h0,         1, 1, 32'h10,        1, 32'hC,         32'h10,  32'hDEAD000C);
    row(0, 2'b00, 32'h0,   32'h0,         0, 1, 32'h100,       0, 32'hC,         32'h10,  32'hDEAD000C);
    row(0, 2'b00, 32'h0,   32'h0,         0, 1, 32'h100,       0, 32'hC,         32'h10,  32'hDEAD000C);
    row(0, 2'b00, 32'h0,   32'h0,         0, 1, 32'h100,       0, 32'hC,         32'h10,  32'hDEAD000C);
    row(0, 2'b00, 32'h0,   32'h0,         1, 1, 32'h100,       0, 32'hC,         32'h10,  32'hDEAD000C);
    row(0, 2'b11, 32'h999, 32'h20,        1, 1, 32'h104,       1, 32'h100,       32'h104, 32'hDEAD0100);
    row(0, 2'b00, 32'h0,   32'h0,         0, 1, 32'h20,        0, 32'h100,       32'h104, 32'hDEAD0100);
    row(0, 2'b01, 32'h400, 32'h0,         0, 1, 32'h20,        0, 32'h100,       32'h104, 32'hDEAD0100);
    row(0, 2'b00, 32'h0,   32'h0,         0, 1, 32'h20,        0, 32'h100,       32'h104, 32'hDEAD0100);
    row(0, 2'b00, 32'h0,   32'h0,         1, 1, 32'h20,        0, 32'h100,       32'h104, 32'hDEAD0100);
    row(0, 2'b00, 32'h0,   32'h0,         1, 1, 32'h400,       0, 32'h100,       32'h104, 32'hDEAD0100);
    row(0, 2'b11, 32'h999, 32'h800,       1, 1, 32'h404,       1, 32'h400,       32'h404, 32'hDEAD0400);
    row(0, 2'b00, 32'h0,   32'h0,         1, 1, 32'h800,       0, 32'h400,       32'h404, 32'hDEAD0400);
    row(0, 2'b10, 32'h0,   32'hFFFFFFFC,  1, 1, 32'h804,       1, 32'h800,       32'h804, 32'hDEAD0800);
    row(0, 2'b00, 32'h0,   32'h0,         1, 1, 32'hFFFFFFFC,  0, 32'h800,       32'h804, 32'hDEAD0800);
    row(0, 2'b01, 32'h40,  32'h0,         0, 1, 32'h0,         1, 32'hFFFFFFFC,  32'h0,   32'hDEADFFFC);
    row(0, 2'b10, 32'h0,   32'h60,        0, 1, 32'h0,         0, 32'hFFFFFFFC,  32'h0,   32'hDEADFFFC);
    row(0, 2'b00, 32'h0,   32'h0,         1, 1, 32'h0,         0, 32'hFFFFFFFC,  32'h0,   32'hDEADFFFC);
    row(0, 2'b01, 32'h200, 32'h0,         0, 1, 32'h60,        0, 32'hFFFFFFFC,  32'h0,   32'hDEADFFFC);
    row(0, 2'b00, 32'h0,   32'h0,         0, 1, 32'h60,        0, 32'hFFFFFFFC,  32'h0,   32'hDEADFFFC);

    rst_n          = 1'b0;
    stall          = 1'b0;
    pcsrc          = 2'b00;
    btgt           = 32'h0;
    jtgt           = 32'h0;
    bus.imem_ready = 1'b0;

    @(negedge clk);
    @(negedge clk);
    check_outputs("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      check_outputs($sformatf("row%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_valid,
                    vecs[i].e_pc, vecs[i].e_pc4, vecs[i].e_instr);
      stall          = vecs[i].stall;
      pcsrc          = vecs[i].pcsrc;
      btgt           = vecs[i].bt;
      jtgt           = vecs[i].jt;
      bus.imem_ready = vecs[i].rdy;
      @(posedge clk);
      @(negedge clk);
    end

    // Reset asserted mid-cycle while a dropped request is outstanding.
    check("drop_req_before_rst", 32'(bus.imem_req), 32'h1);
    pcsrc = 2'b00;
    #2 rst_n = 1'b0;
    #1;
    check_outputs("mid_drop_rst", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0);

    // Release and confirm fetch restarts from RESET_PC with zero-wait memory.
    @(negedge clk);
    bus.imem_ready = 1'b1;
    rst_n = 1'b1;
    #1;
    check("restart_idle_req", 32'(bus.imem_req), 32'h0);
    @(posedge clk);
    @(negedge clk);
    check("restart_req", 32'(bus.imem_req), 32'h1);
    check("restart_addr", bus.imem_addr, 32'h0);
    check("restart_valid0", 32'(if_valid), 32'h0);
    @(posedge clk);
    @(negedge clk);
    check_outputs("restart_cap", 1'b1, 32'h4, 1'b1, 32'h0, 32'h4, 32'hDEAD0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
